forward_neuron_core: RTL and testbench
======================================

# forward_neuron_core

Forward-pass counterpart of the backprop neuron core. It serially accumulates N_INPUTS activation×weight products plus a bias, scales back to fixed point with saturation, and applies a piecewise-linear sigmoid. It produces the `activation_current` / `activation_prev` values that the backward pass consumes. Inputs arrive on a valid/ready stream; the result leaves on a valid/ready output that holds until accepted.

## Interface

**Parameters**
- WIDTH, 16, signed fixed-point data width.
- FRAC_BITS, 8, fractional bits (ONE = 1<<FRAC_BITS).
- N_INPUTS, 8, products per neuron (≥1).

**Ports**
- clk  in  1  clock.
- rst_n  in  1  reset; asynchronous, active-low.
- start  in  1  begin a neuron; sampled only in IDLE.
- bias  in  WIDTH  signed bias; captured on accepted start.
- in_valid  in  1  input pair valid.
- in_ready  out  1  core accepts pair (high only in ACCUM).
- in_act  in  WIDTH  signed previous-layer activation.
- in_weight  in  WIDTH  signed weight.
- out_valid  out  1  results valid.
- out_ready  in  1  downstream accepts results.
- sum_out  out  WIDTH  saturated pre-activation z.
- act_out  out  WIDTH  sigmoid(z), range 0..ONE.
- busy  out  1  state ≠ IDLE.

## Operation

- Accumulator width: ACC_W = 2*WIDTH + $clog2(N_INPUTS) + 2. It never overflows internally.
- States: IDLE, ACCUM, ACTIVATE, OUTPUT.
  - IDLE: on start, acc ← sign-extended bias <<< FRAC_BITS and cnt ← 0; go to ACCUM.
  - ACCUM: in_ready = 1. On in_valid&&in_ready, acc += sign-extended full product in_act*in_weight and cnt++. On the accept with cnt == N_INPUTS-1, go to ACTIVATE.
  - ACTIVATE (1 cycle): z_full = acc >>> FRAC_BITS (arithmetic; floor). Saturate to WIDTH signed (max 0x7FFF, min 0x8000 for WIDTH=16). Compute the sigmoid, register sum_out and act_out, go to OUTPUT.
  - OUTPUT: out_valid = 1. sum_out and act_out are held stable. On out_ready, go to IDLE.
- Sigmoid (PLAN), with a = |z| (a of the minimum value is treated as ≥5):
  - a ≥ 5.0: y = ONE.
  - 2.375 ≤ a < 5: y = (a>>>5) + 0.84375.
  - 1.0 ≤ a < 2.375: y = (a>>>3) + 0.625.
  - a < 1.0: y = (a>>>2) + 0.5.
  - z < 0: act = ONE − y; otherwise act = y.
  - Constants are quantized to FRAC_BITS by truncation. For FRAC_BITS=8: 5.0=1280, 2.375=608, 0.84375=216, 0.625=160, 0.5=128.
- start is ignored outside IDLE. in_valid is ignored outside ACCUM. No extra pairs are accepted after the Nth.
- sum_out and act_out are not cleared on return to IDLE; they hold their last value.

## Timing

- Reset values: state IDLE, in_ready 0, out_valid 0, busy 0, sum_out 0, act_out 0, acc 0, cnt 0.
- Reset mid-operation returns to IDLE immediately. Any partial sum is discarded.
- start is accepted at edge t0. in_ready is high from t0 onward.
- If the last pair is accepted at edge tk, ACTIVATE occupies cycle tk..tk+1. out_valid rises after edge tk+1, so latency from last accept to out_valid is 1 cycle.
- out_valid && out_ready at edge tj → IDLE after tj. out_valid is low in cycle tj+1.
- start asserted in the same cycle as the output handshake is ignored. Earliest restart is edge tj+1.
- Minimum period with continuous valid/ready: N_INPUTS + 3 cycles per neuron.
- out_ready low stalls indefinitely. Outputs are unchanged during the stall and in_ready stays 0.

## Test plan

All cases use WIDTH=16, FRAC_BITS=8, N_INPUTS=4.

1. Assert reset, then release with idle inputs → all outputs 0 and busy 0. A start pulse sets busy = 1 on the next cycle.
2. Basic: bias 0, in_act 256 ×4, in_weight 64 ×4, continuous valid and out_ready=1 → sum_out 256, act_out 192. out_valid is high exactly one cycle after the 4th accept and lasts 1 cycle.
3. Negative region: same as case 2 but weights −64 → sum_out −256 (0xFF00), act_out 64. With bias 0 and weights 0 → sum_out 0, act_out 128.
4. Saturation: bias 0x7FFF, acts and weights all 0x7FFF → sum_out 0x7FFF, act_out 256. With bias 0x8000, acts 0x7FFF and weights 0x8000 → sum_out 0x8000, act_out 0.
5. Backpressure: in_valid gaps of 0–3 cycles plus a 6th pair offered, and out_ready low for 5 cycles with start pulsed during OUTPUT → exactly 4 pairs accepted, outputs stable while stalled, start ignored, result matches case 2.
6. Reset mid-ACCUM after 2 accepts, then a fresh run of case 3 → in_ready drops immediately and the result is sum_out −256, act_out 64, with no residue from the aborted run.

Source files
------------

// File: rtl/forward_neuron_core.sv
// Forward-pass neuron: serial MAC of N_INPUTS act*weight pairs plus bias, floor-rescale with
// saturation, then a piecewise-linear sigmoid. Results hold on a valid/ready output.
module forward_neuron_core #(
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned FRAC_BITS = 8,
    parameter int unsigned N_INPUTS  = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic signed [WIDTH-1:0] bias,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [WIDTH-1:0] in_act,
    input  logic signed [WIDTH-1:0] in_weight,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic        [WIDTH-1:0] sum_out,
    output logic        [WIDTH-1:0] act_out,
    output logic                    busy
);

    localparam int unsigned ACC_W = 2 * WIDTH + $clog2(N_INPUTS) + 2;
    localparam int unsigned CNT_W = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;
    localparam logic [CNT_W-1:0] LastCnt = CNT_W'(N_INPUTS - 1);

    localparam logic signed [ACC_W-1:0] SatMax = {{(ACC_W - WIDTH + 1){1'b0}}, {(WIDTH - 1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SatMin = ~SatMax;
    localparam logic [WIDTH-1:0] MinVal = {1'b1, {(WIDTH - 1){1'b0}}};
    localparam logic [WIDTH-1:0] MaxVal = ~MinVal;

    // Sigmoid breakpoints and offsets, truncated to FRAC_BITS.
    localparam logic [WIDTH-1:0] One    = WIDTH'(1) << FRAC_BITS;
    localparam logic [WIDTH-1:0] Five   = WIDTH'(5) << FRAC_BITS;
    localparam logic [WIDTH-1:0] BrkHi  = (WIDTH'(19) << FRAC_BITS) >> 3;
    localparam logic [WIDTH-1:0] OffHi  = (WIDTH'(27) << FRAC_BITS) >> 5;
    localparam logic [WIDTH-1:0] OffMid = (WIDTH'(5) << FRAC_BITS) >> 3;
    localparam logic [WIDTH-1:0] OffLo  = One >> 1;

    typedef enum logic [1:0] {StIdle, StAccum, StActivate, StOutput} state_e;

    state_e                   state_q, state_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic        [CNT_W-1:0]  cnt_q, cnt_d;
    logic        [WIDTH-1:0]  sum_q, sum_d;
    logic        [WIDTH-1:0]  act_q, act_d;

    logic signed [2*WIDTH-1:0] prod;
    logic signed [ACC_W-1:0]   z_full;
    logic        [WIDTH-1:0]   z_sat;
    logic        [WIDTH-1:0]   mag;
    logic        [WIDTH-1:0]   y;
    logic        [WIDTH-1:0]   act_val;

    assign prod = in_act * in_weight;

    always_comb begin
        z_full = acc_q >>> FRAC_BITS;
        if (z_full > SatMax) begin
            z_sat = MaxVal;
        end else if (z_full < SatMin) begin
            z_sat = MinVal;
        end else begin
            z_sat = z_full[WIDTH-1:0];
        end

        mag = z_sat[WIDTH-1] ? (~z_sat + 1'b1) : z_sat;
        // |MinVal| does not fit; it lands in the saturated region explicitly.
        if (z_sat == MinVal || mag >= Five) begin
            y = One;
        end else if (mag >= BrkHi) begin
            y = (mag >> 5) + OffHi;
        end else if (mag >= One) begin
            y = (mag >> 3) + OffMid;
        end else begin
            y = (mag >> 2) + OffLo;
        end
        act_val = z_sat[WIDTH-1] ? (One - y) : y;
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        act_d   = act_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    acc_d   = ACC_W'(bias) <<< FRAC_BITS;
                    cnt_d   = '0;
                    state_d = StAccum;
                end
            end
            StAccum: begin
                if (in_valid) begin
                    acc_d = acc_q + ACC_W'(prod);
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LastCnt) begin
                        state_d = StActivate;
                    end
                end
            end
            StActivate: begin
                sum_d   = z_sat;
                act_d   = act_val;
                state_d = StOutput;
            end
            StOutput: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            acc_q   <= '0;
            cnt_q   <= '0;
            sum_q   <= '0;
            act_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            act_q   <= act_d;
        end
    end

    assign in_ready  = (state_q == StAccum);
    assign out_valid = (state_q == StOutput);
    assign busy      = (state_q != StIdle);
    assign sum_out   = sum_q;
    assign act_out   = act_q;

endmodule

// File: tb/tb_forward_neuron_core.sv
// Directed bench for forward_neuron_core (WIDTH=16, FRAC_BITS=8, N_INPUTS=4) with an
// expected-result queue filled at start and drained when out_valid rises.
module tb_forward_neuron_core;

    localparam int WIDTH     = 16;
    localparam int FRAC_BITS = 8;
    localparam int N_INPUTS  = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [WIDTH-1:0] bias = '0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] in_act = '0;
    logic [WIDTH-1:0] in_weight = '0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [WIDTH-1:0] sum_out;
    logic [WIDTH-1:0] act_out;
    logic             busy;

    typedef struct packed {
        logic [WIDTH-1:0] s;
        logic [WIDTH-1:0] a;
    } exp_t;

    exp_t             exp_q[$];
    logic [WIDTH-1:0] act_v[N_INPUTS];
    logic [WIDTH-1:0] wt_v[N_INPUTS];
    int               checks = 0;
    int               errors = 0;

    forward_neuron_core #(
        .WIDTH    (WIDTH),
        .FRAC_BITS(FRAC_BITS),
        .N_INPUTS (N_INPUTS)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .bias     (bias),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_act   (in_act),
        .in_weight(in_weight),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .sum_out  (sum_out),
        .act_out  (act_out),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv)
        else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Reference: wide integer MAC, floor shift, clamp, then the four-segment sigmoid.
    function automatic exp_t model(input logic [WIDTH-1:0] b);
        exp_t   e;
        longint acc;
        longint z;
        longint m;
        longint yy;
        acc = longint'($signed(b)) * 256;
        for (int i = 0; i < N_INPUTS; i++) begin
            acc += longint'($signed(act_v[i])) * longint'($signed(wt_v[i]));
        end
        z = acc >>> FRAC_BITS;
        if (z > 32767) z = 32767;
        if (z < -32768) z = -32768;
        m = (z < 0) ? -z : z;
        if (m >= 1280) yy = 256;
        else if (m >= 608) yy = (m >> 5) + 216;
        else if (m >= 256) yy = (m >> 3) + 160;
        else yy = (m >> 2) + 128;
        if (z < 0) yy = 256 - yy;
        e.s = z[WIDTH-1:0];
        e.a = yy[WIDTH-1:0];
        return e;
    endfunction

    task automatic run(input logic [WIDTH-1:0] b, input int gap_max, input int stall,
                       input bit extra);
        exp_t e;
        int   accepted;
        int   waited;
        int   g;
        exp_q.push_back(model(b));
        bias  = b;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("busy_after_start", busy, 1);
        check("in_ready_accum", in_ready, 1);
        accepted = 0;
        for (int i = 0; i < N_INPUTS; i++) begin
            g = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
            in_valid = 1'b0;
            repeat (g) tick();
            in_valid  = 1'b1;
            in_act    = act_v[i];
            in_weight = wt_v[i];
            waited    = 0;
            while (!in_ready && waited < 20) begin
                tick();
                waited++;
            end
            check("accept_wait", waited < 20, 1);
            if (in_ready) accepted++;
            tick();
        end
        // Optionally keep offering a further pair; none may be taken.
        in_valid  = extra;
        in_act    = 16'h1234;
        in_weight = 16'h0777;
        out_ready = (stall == 0);
        check("activate_no_valid", out_valid, 0);
        check("activate_no_ready", in_ready, 0);
        if (in_valid && in_ready) accepted++;
        tick();
        check("out_valid_rise", out_valid, 1);
        if (exp_q.size() == 0) begin
            check("scoreboard_empty", 1, 0);
        end else begin
            e = exp_q.pop_front();
            check("sum_out", sum_out, e.s);
            check("act_out", act_out, e.a);
            for (int s = 0; s < stall; s++) begin
                start = (s == 2);
                if (in_valid && in_ready) accepted++;
                tick();
                check("stall_valid", out_valid, 1);
                check("stall_in_ready", in_ready, 0);
                check("stall_sum", sum_out, e.s);
                check("stall_act", act_out, e.a);
            end
        end
        out_ready = 1'b1;
        start     = extra;
        if (in_valid && in_ready) accepted++;
        tick();
        start    = 1'b0;
        in_valid = 1'b0;
        check("out_valid_fall", out_valid, 0);
        check("idle_after_hs", busy, 0);
        check("pairs_accepted", accepted, N_INPUTS);
    endtask

    task automatic set_pairs(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] w);
        for (int i = 0; i < N_INPUTS; i++) begin
            act_v[i] = a;
            wt_v[i]  = w;
        end
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_sum", sum_out, 0);
        check("rst_act", act_out, 0);

        set_pairs(16'd256, 16'd64);
        run(16'h0000, 0, 0, 1'b0);
        set_pairs(16'd256, 16'hFFC0);
        run(16'h0000, 0, 0, 1'b0);
        set_pairs(16'd256, 16'h0000);
        run(16'h0000, 0, 0, 1'b0);
        run(16'd768, 0, 0, 1'b0);
        run(16'd100, 0, 0, 1'b0);
        run(16'hFD44, 0, 0, 1'b0);

        set_pairs(16'h7FFF, 16'h7FFF);
        run(16'h7FFF, 0, 0, 1'b0);
        set_pairs(16'h7FFF, 16'h8000);
        run(16'h8000, 0, 0, 1'b0);

        set_pairs(16'd256, 16'd64);
        run(16'h0000, 3, 5, 1'b1);

        // Abort mid-accumulation; the following run must show no residue.
        set_pairs(16'd256, 16'd64);
        bias  = 16'h0400;
        start = 1'b1;
        tick();
        start     = 1'b0;
        in_valid  = 1'b1;
        in_act    = 16'd256;
        in_weight = 16'd64;
        tick();
        tick();
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_in_ready", in_ready, 0);
        check("abort_busy", busy, 0);
        check("abort_sum", sum_out, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        set_pairs(16'd256, 16'hFFC0);
        run(16'h0000, 0, 0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
